// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter
// Byte-serial RAM/IO port shared by I-cache fetches and the load/store buffer.
// Optional: MEM_ARBITER_IO_STALL_EN holds IO-space stores while io_buffer_full.
// Revision: 1.0
// ============================================================================
module mem_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        ready,
   input  logic        clear,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_STORE = 3'd3,
      S_COOL  = 3'd4
   } state_t;

   state_t      r_state;
   logic        r_last_ls;
   logic [31:0] r_base;
   logic [31:0] r_wdata;
   logic [31:0] r_rbuf;
   logic [2:0]  r_len;
   logic [2:0]  r_cnt;

   logic        w_ls_ok;
   logic        w_grant_if;
   logic        w_grant_ls;
   logic [2:0]  w_ls_len;
   logic [2:0]  w_cnt_nxt;
   logic [1:0]  w_lane;
   logic [31:0] w_rword;

`ifdef MEM_ARBITER_IO_STALL_EN
   localparam logic [31:0] C_IO_BASE = 32'h0003_0000;
   assign w_ls_ok = ls_req &&
                    !(ls_we && io_buffer_full && ((ls_addr & C_IO_BASE) == C_IO_BASE));
`else
   logic w_unused_io;
   assign w_unused_io = io_buffer_full;
   assign w_ls_ok     = ls_req;
`endif

   // Round-robin: on a tie the requester not granted last wins.
   assign w_grant_ls = w_ls_ok && (!if_req || !r_last_ls);
   assign w_grant_if = if_req && !w_grant_ls;

   assign w_ls_len  = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
   assign w_cnt_nxt = r_cnt + 3'd1;
   // Byte arriving on mem_din belongs to the address issued one cycle earlier.
   assign w_lane    = r_cnt[1:0] - 2'd1;

   always_comb begin
      w_rword = r_rbuf;
      case (w_lane)
         2'd0:    w_rword[7:0]   = mem_din;
         2'd1:    w_rword[15:8]  = mem_din;
         2'd2:    w_rword[23:16] = mem_din;
         default: w_rword[31:24] = mem_din;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_last_ls <= 1'b0;
         r_base    <= 32'd0;
         r_wdata   <= 32'd0;
         r_rbuf    <= 32'd0;
         r_len     <= 3'd0;
         r_cnt     <= 3'd0;
         mem_a     <= 32'd0;
         mem_dout  <= 8'd0;
         mem_wr    <= 1'b0;
         if_done   <= 1'b0;
         ls_done   <= 1'b0;
         if_data   <= 32'd0;
         ls_rdata  <= 32'd0;
      end else if (ready) begin
         if_done <= 1'b0;
         ls_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!clear && (w_grant_if || w_grant_ls)) begin
                  r_cnt     <= 3'd0;
                  r_rbuf    <= 32'd0;
                  r_last_ls <= w_grant_ls;
                  if (w_grant_if) begin
                     r_base  <= if_addr;
                     mem_a   <= if_addr;
                     r_len   <= 3'd4;
                     r_state <= S_FETCH;
                  end else begin
                     r_base <= ls_addr;
                     mem_a  <= ls_addr;
                     r_len  <= w_ls_len;
                     if (ls_we) begin
                        r_state  <= S_STORE;
                        mem_wr   <= 1'b1;
                        mem_dout <= ls_wdata[7:0];
                        r_wdata  <= ls_wdata >> 8;
                     end else begin
                        r_state <= S_LOAD;
                     end
                  end
               end
            end
            S_FETCH, S_LOAD: begin
               if (clear) begin
                  r_state <= S_IDLE;
                  mem_wr  <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_nxt;
                  if (w_cnt_nxt < r_len)
                     mem_a <= r_base + {29'd0, w_cnt_nxt};
                  if (r_cnt != 3'd0)
                     r_rbuf <= w_rword;
                  if (r_cnt == r_len) begin
                     r_state <= S_COOL;
                     if (r_state == S_FETCH) begin
                        if_done <= 1'b1;
                        if_data <= w_rword;
                     end else begin
                        ls_done  <= 1'b1;
                        ls_rdata <= w_rword;
                     end
                  end
               end
            end
            S_STORE: begin
               // A store is never torn: clear has no effect here.
               if (w_cnt_nxt < r_len) begin
                  r_cnt    <= w_cnt_nxt;
                  mem_a    <= r_base + {29'd0, w_cnt_nxt};
                  mem_dout <= r_wdata[7:0];
                  r_wdata  <= r_wdata >> 8;
               end else begin
                  mem_wr  <= 1'b0;
                  ls_done <= 1'b1;
                  r_state <= S_COOL;
               end
            end
            S_COOL:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Self-checking bench for mem_arbiter: vector table plus scoreboarded corner sequences.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset, ready, clear, io_buffer_full;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        if_req, if_done, ls_req, ls_we, ls_done;
   logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata;
   logic [1:0]  ls_size;

   mem_arbiter dut (
      .clk(clk), .reset(reset), .ready(ready), .clear(clear),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      case (a)
         32'h100: return 8'h13;
         32'h101: return 8'h00;
         32'h102: return 8'h00;
         32'h103: return 8'h93;
         default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
      endcase
   endfunction

   // RAM stalls together with the controller when ready is low.
   always @(posedge clk) if (ready) mem_din <= ram_byte(mem_a);

   function automatic int len_of(input bit is_fetch, input logic [1:0] size);
      if (is_fetch || size >= 2'd2) return 4;
      return (size == 2'd0) ? 1 : 2;
   endfunction

   function automatic logic [31:0] read_word(input logic [31:0] a, input int n);
      logic [31:0] w;
      w = 32'd0;
      for (int i = 0; i < n; i++) w[8*i +: 8] = ram_byte(a + i);
      return w;
   endfunction

   typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
   typedef struct packed { logic st; logic [31:0] d; } ls_t;
   typedef struct {
      bit          is_fetch;
      bit          we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   wr_t         wq[$];
   logic [31:0] fq[$];
   ls_t         lq[$];
   int          checks = 0, errors = 0;
   bit          saw_if, saw_ls;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock; scoreboard outputs produced by an enabled edge.
   task automatic tick();
      bit   en;
      wr_t  w;
      ls_t  l;
      en = ready && !reset;
      @(negedge clk);
      saw_if = 1'b0;
      saw_ls = 1'b0;
      if (en) begin
         if (mem_wr) begin
            if (wq.size() == 0) check("unexpected_mem_wr", {31'd0, mem_wr}, 32'd0);
            else begin
               w = wq.pop_front();
               check("wr_addr", mem_a, w.a);
               check("wr_data", {24'd0, mem_dout}, {24'd0, w.d});
            end
         end
         if (if_done) begin
            saw_if = 1'b1;
            if (fq.size() == 0) check("spurious_if_done", {31'd0, if_done}, 32'd0);
            else check("if_data", if_data, fq.pop_front());
         end
         if (ls_done) begin
            saw_ls = 1'b1;
            if (lq.size() == 0) check("spurious_ls_done", {31'd0, ls_done}, 32'd0);
            else begin
               l = lq.pop_front();
               if (l.st) check("store_bytes_left", wq.size(), 32'd0);
               else      check("ls_rdata", ls_rdata, l.d);
            end
         end
      end
   endtask

   task automatic issue(input vec_t v);
      if (v.is_fetch) begin
         if_req = 1'b1; if_addr = v.addr;
         fq.push_back(v.exp_data);
      end else begin
         ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_size = v.size; ls_wdata = v.wdata;
         if (v.we)
            for (int i = 0; i < len_of(1'b0, v.size); i++)
               wq.push_back({v.addr + i, v.wdata[8*i +: 8]});
         lq.push_back({v.we, v.exp_data});
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int lat;
      issue(v);
      lat = 0;
      do begin tick(); lat++; end while (!(saw_if || saw_ls) && lat < 40);
      if_req = 1'b0; ls_req = 1'b0;
      check(name, lat, v.exp_lat);
      tick();
   endtask

   function automatic vec_t mk(input bit f, input bit we, input logic [31:0] a,
                               input logic [1:0] sz, input logic [31:0] wd);
      vec_t v;
      int   n;
      n = len_of(f, sz);
      v.is_fetch = f; v.we = we; v.addr = a; v.size = sz; v.wdata = wd;
      v.exp_data = we ? 32'd0 : read_word(a, n);
      v.exp_lat  = we ? n + 1 : n + 2;
      return v;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_a"}, mem_a, 32'd0);
      check({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
      check({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
      check({tag, "_dones"}, {30'd0, if_done, ls_done}, 32'd0);
      check({tag, "_if_data"}, if_data, 32'd0);
      check({tag, "_ls_rdata"}, ls_rdata, 32'd0);
   endtask

   // Tie between fetch and load; order encoded as decimal digits, 1 = fetch, 2 = lsu.
   task automatic tie_round(input bit rereq, input int exp_order, input string name);
      int pend_ls, pend_if, ord;
      issue(mk(1'b1, 1'b0, 32'h100, 2'd2, 32'd0));
      issue(mk(1'b0, 1'b0, 32'h30, 2'd0, 32'd0));
      pend_if = 1; pend_ls = rereq ? 2 : 1; ord = 0;
      for (int k = 0; k < 60 && (pend_if + pend_ls) > 0; k++) begin
         tick();
         if (saw_ls) begin
            ord = ord * 10 + 2; pend_ls--;
            if (pend_ls == 0) ls_req = 1'b0;
            else issue(mk(1'b0, 1'b0, 32'h31, 2'd0, 32'd0));
         end
         if (saw_if) begin
            ord = ord * 10 + 1; pend_if = 0; if_req = 1'b0;
         end
      end
      check(name, ord, exp_order);
      tick();
   endtask

   vec_t tbl[11];
   vec_t v;
   int   lat;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got hang expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; ready = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
      if_req = 1'b0; if_addr = 32'd0; ls_req = 1'b0; ls_we = 1'b0;
      ls_addr = 32'd0; ls_size = 2'd0; ls_wdata = 32'd0;

      tbl[0]  = mk(1'b1, 1'b0, 32'h0000_0100, 2'd2, 32'd0);
      tbl[0].exp_data = 32'h9300_0013;
      tbl[1]  = mk(1'b0, 1'b1, 32'h0000_2002, 2'd1, 32'hDEAD_BEEF);
      tbl[2]  = mk(1'b0, 1'b0, 32'h0000_0030, 2'd0, 32'd0);
      tbl[3]  = mk(1'b0, 1'b0, 32'h0000_0041, 2'd1, 32'd0);
      tbl[4]  = mk(1'b0, 1'b0, 32'h0000_0200, 2'd2, 32'd0);
      tbl[5]  = mk(1'b0, 1'b0, 32'h0000_0300, 2'd3, 32'd0);
      tbl[6]  = mk(1'b0, 1'b1, 32'h0000_0055, 2'd0, 32'h1234_56A5);
      tbl[7]  = mk(1'b0, 1'b1, 32'h0000_1000, 2'd2, 32'hCAFE_F00D);
      tbl[8]  = mk(1'b0, 1'b1, 32'hFFFF_FFFF, 2'd1, 32'h0000_A55A);
      tbl[9]  = mk(1'b0, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'd0);
      tbl[10] = mk(1'b1, 1'b0, 32'hFFFF_FFFC, 2'd2, 32'd0);

      repeat (3) tick();
      reset = 1'b0;
      check_reset_outputs("reset");

      for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d_latency", i));

      // Flush during byte 2 of a fetch: aborted, and IDLE is reached immediately.
      if_req = 1'b1; if_addr = 32'h400;
      repeat (3) tick();
      check("flush_fetch_addr", mem_a, 32'h402);
      clear = 1'b1; if_req = 1'b0;
      tick();
      clear = 1'b0;
      check("flush_fetch_mem_wr", {31'd0, mem_wr}, 32'd0);
      run_vec(mk(1'b0, 1'b0, 32'h77, 2'd0, 32'd0), "after_flush_latency");

      // Flush during byte 1 of a word store: store completes.
      issue(mk(1'b0, 1'b1, 32'h800, 2'd2, 32'h1122_3344));
      tick(); tick();
      clear = 1'b1;
      lat = 2;
      while (!saw_ls && lat < 40) begin tick(); lat++; end
      clear = 1'b0; ls_req = 1'b0;
      check("flush_store_latency", lat, 32'd5);
      tick();

      // Freeze for 3 cycles in the middle of a byte load.
      issue(mk(1'b0, 1'b0, 32'h30, 2'd0, 32'd0));
      tick();
      check("freeze_addr0", mem_a, 32'h30);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("freeze_mem_a", mem_a, 32'h30);
         check("freeze_ls_done", {31'd0, ls_done}, 32'd0);
      end
      ready = 1'b1;
      lat = 0;
      do begin tick(); lat++; end while (!saw_ls && lat < 40);
      ls_req = 1'b0;
      check("freeze_resume_latency", lat, 32'd2);
      tick();

`ifdef MEM_ARBITER_IO_STALL_EN
      io_buffer_full = 1'b1;
      issue(mk(1'b0, 1'b1, 32'h0003_0000, 2'd0, 32'h0000_0077));
      for (int i = 0; i < 4; i++) begin
         tick();
         check("io_stall_no_wr", {31'd0, mem_wr}, 32'd0);
      end
      io_buffer_full = 1'b0;
      tick();
      check("io_stall_wr", {31'd0, mem_wr}, 32'd1);
      lat = 0;
      do begin tick(); lat++; end while (!saw_ls && lat < 40);
      ls_req = 1'b0;
      check("io_stall_done_latency", lat, 32'd1);
      tick();
`else
      io_buffer_full = 1'b1;
      run_vec(mk(1'b0, 1'b1, 32'h0003_0000, 2'd0, 32'h0000_0077), "io_store_latency");
      io_buffer_full = 1'b0;
`endif

      // Reset in the middle of a word store (last grant = lsu).
      issue(mk(1'b0, 1'b1, 32'h1000, 2'd2, 32'h0BAD_F00D));
      tick(); tick();
      reset = 1'b1; ls_req = 1'b0;
      tick();
      reset = 1'b0;
      check_reset_outputs("midreset");
      wq.delete(); lq.delete(); fq.delete();

      tie_round(1'b0, 21, "tie_after_reset_order");
      tie_round(1'b0, 21, "tie_after_fetch_order");
      tie_round(1'b1, 212, "round_robin_order");

      check("queues_empty", wq.size() + fq.size() + lq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Byte-serial memory controller that shares the single 8-bit RAM/IO port between the instruction-cache miss path and the load/store buffer. It accepts word-wide fetch requests and 1/2/4-byte load/store requests, arbitrates round-robin, and sequences each transfer one byte per cycle. A pipeline flush aborts fetches and loads but never tears a store.

## Interface
- IO_BASE, 32'h0003_0000: addresses with bits [17:16] == 2'b11 are IO space.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ready  in  1  global enable; when low, all state and outputs hold.
- clear  in  1  pipeline flush.
- mem_din  in  8  RAM read byte, valid the cycle after its address is driven.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  write strobe; 1 = write.
- io_buffer_full  in  1  IO write buffer full.
- if_req  in  1  fetch request; held until if_done or clear.
- if_addr  in  32  fetch address, word-aligned.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched word, little-endian.
- ls_req  in  1  load/store request; held until ls_done.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  32  byte address.
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- ls_wdata  in  32  store data; low n bytes used.
- ls_done  out  1  one-cycle pulse.
- ls_rdata  out  32  load data, zero-extended.

## Operation
- States: IDLE, FETCH, LOAD, STORE, COOL.
- IDLE grants only when ready=1 and clear=0.
  - Only one requester pending: grant it.
  - Both pending: grant the requester not granted last. The last-grant bit resets to "fetch", so the LSB wins the first tie.
- On grant, latch the address, size (fetch = 4), and write data. Clear the byte counter.
- FETCH/LOAD: drive mem_a = base + i for i = 0..n-1 on successive cycles. Capture mem_din into byte lane i one cycle after address i.
- STORE: drive mem_a = base + i, mem_dout = byte i, and mem_wr = 1 for n consecutive cycles.
- Completion sets the matching done flag for one cycle and enters COOL. COOL ignores requests for one cycle, then returns to IDLE. This gives the requester time to drop req and prevents a double issue.
- Address arithmetic is 32-bit and wraps modulo 2^32; 32'hFFFF_FFFF + 1 = 0.
- clear:
  - In FETCH/LOAD: abort. No done pulse, mem_wr = 0, next state IDLE. Partial data is discarded.
  - In STORE: ignored; the store runs to completion and ls_done pulses.
  - In IDLE/COOL: no grant that cycle.
- ready low: freeze state, counter, and all outputs (including mem_wr) for any number of cycles, then resume exactly.
- Reset, including mid-transfer: state IDLE, last-grant = fetch, counter 0, mem_a 0, mem_dout 0, mem_wr 0, if_done 0, ls_done 0, if_data 0, ls_rdata 0.

## Timing
- Grant occurs at edge E; byte 0 address is visible after E.
- Read of n bytes: done visible after edge E+n+1, with data valid in the same cycle.
- Fetch latency is therefore 5 cycles; a byte load takes 2.
- Write of n bytes: mem_wr = 1 after edges E..E+n-1. At edge E+n, mem_wr = 0 and ls_done = 1.
- Minimum spacing between two grants: n+3 cycles (read) or n+2 cycles (write), including COOL.
- mem_wr is never 1 outside STORE.

## Configuration
- MEM_ARBITER_IO_STALL_EN defined:
  - A store whose address is in IO space is not granted while io_buffer_full = 1. It waits in IDLE.
  - A pending fetch may be granted meanwhile under normal round-robin.
  - A store already in progress is not interrupted.
- Undefined: io_buffer_full is ignored and IO stores are granted like any other store.

## Test plan
- Fetch: if_addr = 0x100 with RAM[0x100..0x103] = 13 00 00 93 -> if_done after 5 cycles, if_data = 0x9300_0013; mem_wr stays 0 throughout.
- Half store: ls_we = 1, ls_size = 1, ls_addr = 0x2002, ls_wdata = 0xDEAD_BEEF -> mem_wr = 1 for 2 cycles writing EF@0x2002 then BE@0x2003; ls_done in the next cycle.
- Tie: if_req and ls_req asserted together after reset -> LSB granted first and fetch granted next. A further tie -> LSB granted again, since the last grant was the fetch.
- Flush: clear during byte 2 of a fetch -> no if_done, state IDLE, mem_wr = 0. Clear during byte 1 of a word store -> all 4 bytes written, ls_done pulses.
- Freeze: ready held low for 3 cycles mid byte load at 0x30 -> outputs frozen; after resume, ls_rdata = RAM[0x30] zero-extended.
- IO stall (macro on): byte store to 0x30000 with io_buffer_full = 1 for 4 cycles -> no mem_wr until io_buffer_full falls; grant on the next edge and the write occurs.
